// File: rtl/wb_sram_host_bridge_pkg.sv
// Shared types and helpers for big-endian byte masters bridging onto 32-bit Wishbone.
package wb_sram_host_bridge_pkg;

   localparam int unsigned HADDR_W = 13;
   localparam int unsigned HDAT_W  = 8;
   localparam int unsigned WB_AW   = 32;
   localparam int unsigned WB_DW   = 32;
   localparam int unsigned WB_SW   = 4;
   localparam int unsigned LANE_W  = 2;
   localparam int unsigned CNT_W   = 8;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WR   = 2'd1;
   localparam state_t ST_RD   = 2'd2;
   localparam state_t ST_HOLD = 2'd3;

   // Raw host pins as one bus, so address, data and strobes share a sampling pipeline
   typedef struct packed {
      logic [HADDR_W-1:0] addr;
      logic [HDAT_W-1:0]  di;
      logic               nwe;
      logic               noe;
      logic               ncs;
   } host_bus_t;

   localparam int unsigned HOST_BUS_W = $bits(host_bus_t);

   // Strobes idle high so a reset sampler never fakes an edge
   localparam host_bus_t HOST_BUS_IDLE = '{addr: '0, di: '0, nwe: 1'b1, noe: 1'b1, ncs: 1'b1};

   // Big-endian lane select: byte 0 lives in bits [31:24]
   function automatic logic [WB_SW-1:0] lane_sel(input logic [LANE_W-1:0] lane);
      case (lane)
         2'd0:    lane_sel = 4'b1000;
         2'd1:    lane_sel = 4'b0100;
         2'd2:    lane_sel = 4'b0010;
         default: lane_sel = 4'b0001;
      endcase
   endfunction

   // Big-endian byte extraction matching lane_sel
   function automatic logic [HDAT_W-1:0] lane_byte(input logic [WB_DW-1:0] dat,
                                                   input logic [LANE_W-1:0] lane);
      case (lane)
         2'd0:    lane_byte = dat[31:24];
         2'd1:    lane_byte = dat[23:16];
         2'd2:    lane_byte = dat[15:8];
         default: lane_byte = dat[7:0];
      endcase
   endfunction

endpackage

// File: rtl/wb_sram_host_bridge_sync.sv
// Three-stage sampler with per-bit rise/fall detect between the last two stages.
module host_port_sync #(
   parameter int unsigned W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] s2,
   output logic [W-1:0] s3,
   output logic [W-1:0] rise_c,
   output logic [W-1:0] fall_c
);

   logic [W-1:0] s1;

   // Sampling pipeline; s3 is the previous s2 for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= RST_VAL;
         s2 <= RST_VAL;
         s3 <= RST_VAL;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise_c = s2 & ~s3;
   assign fall_c = ~s2 & s3;

endmodule

// File: rtl/wb_sram_host_bridge.sv
// Async SRAM-style host port to Wishbone classic master; one 32-bit cycle per host strobe.
module wb_sram_host_bridge
   import wb_sram_host_bridge_pkg::*;
#(
   parameter logic [31:0] BASE_ADR = 32'h0000_0000,
   parameter logic [7:0]  TIMEOUT  = 8'd255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [HADDR_W-1:0]  host_addr,
   input  logic [HDAT_W-1:0]   host_di,
   input  logic                host_nwe,
   input  logic                host_noe,
   input  logic                host_ncs,
   output logic [HDAT_W-1:0]   host_do,
   output logic                host_doe,
   output logic                host_wait,
   output logic [WB_AW-1:0]    wb_adr_o,
   output logic [WB_DW-1:0]    wb_dat_o,
   input  logic [WB_DW-1:0]    wb_dat_i,
   output logic [WB_SW-1:0]    wb_sel_o,
   output logic                wb_we_o,
   output logic                wb_cyc_o,
   output logic                wb_stb_o,
   input  logic                wb_ack_i,
   output logic                overrun_o,
   output logic                timeout_o
);

   host_bus_t                host_in;
   logic [HOST_BUS_W-1:0]    s2_v, s3_v, rise_v, fall_v;
   host_bus_t                s2, s3, rise, fall;
   state_t                   state_q, next_state;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [LANE_W-1:0]        lane_q, lane_d;
   logic [WB_AW-1:0]         adr_d;
   logic [WB_DW-1:0]         dat_d;
   logic [WB_SW-1:0]         sel_d;
   logic [HDAT_W-1:0]        do_d;
   logic                     we_d, cyc_d, stb_d, doe_d, ovr_d, tmo_d;
   logic                     wr_evt, rd_evt, tmo_hit, unused_sync;

   assign host_in = '{addr: host_addr, di: host_di, nwe: host_nwe, noe: host_noe, ncs: host_ncs};

   host_port_sync #(
      .W       (HOST_BUS_W),
      .RST_VAL (HOST_BUS_W'(HOST_BUS_IDLE))
   ) u_sync (
      .clk    (clk),
      .reset  (reset),
      .d      (host_in),
      .s2     (s2_v),
      .s3     (s3_v),
      .rise_c (rise_v),
      .fall_c (fall_v)
   );

   assign s2   = host_bus_t'(s2_v);
   assign s3   = host_bus_t'(s3_v);
   assign rise = host_bus_t'(rise_v);
   assign fall = host_bus_t'(fall_v);
   assign unused_sync = ^{s2.di, s3.nwe, rise_v, fall_v};

   // Strobe events; a sample with both nwe and noe low fires neither
   assign wr_evt  = rise.nwe & ~s3.ncs & s3.noe;
   assign rd_evt  = fall.noe & ~s2.ncs & s2.nwe;
   assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT - 8'd1));

   assign host_wait = (state_q == ST_WR) || (state_q == ST_RD) ||
                      ((state_q == ST_IDLE) && (wr_evt || rd_evt));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state_q;
      case (state_q)
         ST_IDLE: begin
            if (wr_evt)      next_state = ST_WR;
            else if (rd_evt) next_state = ST_RD;
         end
         ST_WR:   if (wb_ack_i || tmo_hit) next_state = ST_IDLE;
         ST_RD:   if (wb_ack_i || tmo_hit) next_state = ST_HOLD;
         ST_HOLD: if (s2.noe || s2.ncs)    next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Next values of all registered outputs and the timeout counter
   always_comb begin
      adr_d  = wb_adr_o;
      dat_d  = wb_dat_o;
      sel_d  = wb_sel_o;
      we_d   = wb_we_o;
      cyc_d  = wb_cyc_o;
      stb_d  = wb_stb_o;
      do_d   = host_do;
      lane_d = lane_q;
      cnt_d  = cnt_q;
      ovr_d  = 1'b0;
      tmo_d  = 1'b0;
      doe_d  = (next_state == ST_HOLD);
      case (state_q)
         ST_IDLE: begin
            if (wr_evt) begin
               adr_d = BASE_ADR + WB_AW'({s3.addr[HADDR_W-1:2], 2'b00});
               sel_d = lane_sel(s3.addr[1:0]);
               dat_d = {4{s3.di}};
               we_d  = 1'b1;
               cyc_d = 1'b1;
               stb_d = 1'b1;
               cnt_d = '0;
            end else if (rd_evt) begin
               adr_d  = BASE_ADR + WB_AW'({s2.addr[HADDR_W-1:2], 2'b00});
               sel_d  = lane_sel(s2.addr[1:0]);
               lane_d = s2.addr[1:0];
               we_d   = 1'b0;
               cyc_d  = 1'b1;
               stb_d  = 1'b1;
               cnt_d  = '0;
            end
         end
         ST_WR, ST_RD: begin
            if (wb_ack_i) begin
               cyc_d = 1'b0;
               stb_d = 1'b0;
               we_d  = 1'b0;
               if (state_q == ST_RD) do_d = lane_byte(wb_dat_i, lane_q);
            end else if (tmo_hit) begin
               cyc_d = 1'b0;
               stb_d = 1'b0;
               we_d  = 1'b0;
               tmo_d = 1'b1;
               do_d  = 8'hFF;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
      if ((state_q != ST_IDLE) && (wr_evt || rd_evt)) ovr_d = 1'b1;
   end

   // Output and bookkeeping registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_adr_o  <= '0;
         wb_dat_o  <= '0;
         wb_sel_o  <= 4'h0;
         wb_we_o   <= 1'b0;
         wb_cyc_o  <= 1'b0;
         wb_stb_o  <= 1'b0;
         host_do   <= 8'h00;
         host_doe  <= 1'b0;
         overrun_o <= 1'b0;
         timeout_o <= 1'b0;
         lane_q    <= '0;
         cnt_q     <= '0;
      end else begin
         wb_adr_o  <= adr_d;
         wb_dat_o  <= dat_d;
         wb_sel_o  <= sel_d;
         wb_we_o   <= we_d;
         wb_cyc_o  <= cyc_d;
         wb_stb_o  <= stb_d;
         host_do   <= do_d;
         host_doe  <= doe_d;
         overrun_o <= ovr_d;
         timeout_o <= tmo_d;
         lane_q    <= lane_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: tb/tb_wb_sram_host_bridge.sv
// Directed bench: vector table of single host accesses plus hand-written corner sequences.
module tb_wb_sram_host_bridge;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [12:0] host_addr = '0;
   logic [7:0]  host_di = '0;
   logic        host_nwe = 1'b1, host_noe = 1'b1, host_ncs = 1'b1;
   logic [7:0]  host_do, w_host_do;
   logic        host_doe, host_wait, w_host_doe, w_host_wait;
   logic [31:0] wb_adr_o, wb_dat_o, w_wb_adr_o, w_wb_dat_o;
   logic [31:0] wb_dat_i = '0;
   logic [3:0]  wb_sel_o, w_wb_sel_o;
   logic        wb_we_o, wb_cyc_o, wb_stb_o, w_wb_we_o, w_wb_cyc_o, w_wb_stb_o;
   logic        wb_ack_i = 1'b0;
   logic        overrun_o, timeout_o, w_overrun_o, w_timeout_o;

   always #5 clk = ~clk;

   wb_sram_host_bridge #(.BASE_ADR(32'h0000_0000), .TIMEOUT(8'd10)) dut (
      .clk(clk), .reset(reset), .host_addr(host_addr), .host_di(host_di),
      .host_nwe(host_nwe), .host_noe(host_noe), .host_ncs(host_ncs),
      .host_do(host_do), .host_doe(host_doe), .host_wait(host_wait),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
      .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
      .overrun_o(overrun_o), .timeout_o(timeout_o));

   wb_sram_host_bridge #(.BASE_ADR(32'hFFFF_FFF0), .TIMEOUT(8'd10)) dut_w (
      .clk(clk), .reset(reset), .host_addr(host_addr), .host_di(host_di),
      .host_nwe(host_nwe), .host_noe(host_noe), .host_ncs(host_ncs),
      .host_do(w_host_do), .host_doe(w_host_doe), .host_wait(w_host_wait),
      .wb_adr_o(w_wb_adr_o), .wb_dat_o(w_wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(w_wb_sel_o),
      .wb_we_o(w_wb_we_o), .wb_cyc_o(w_wb_cyc_o), .wb_stb_o(w_wb_stb_o), .wb_ack_i(wb_ack_i),
      .overrun_o(w_overrun_o), .timeout_o(w_timeout_o));

   int total = 0;
   int bad   = 0;

   // Slave: ack ack_dly+1 clk after the first sampled cyc, when enabled
   logic ack_en = 1'b1;
   int   ack_dly = 1;
   int   ack_cnt = 0;
   always @(posedge clk) begin
      if (wb_cyc_o && wb_stb_o && !wb_ack_i && ack_en) begin
         if (ack_cnt == ack_dly) begin
            wb_ack_i <= 1'b1;
            ack_cnt  <= 0;
         end else begin
            ack_cnt <= ack_cnt + 1;
         end
      end else begin
         wb_ack_i <= 1'b0;
         if (!wb_cyc_o) ack_cnt <= 0;
      end
   end

   // Bus monitor: cycle count, cycle length, captured request, pulse counts
   logic        cyc_prev = 1'b0;
   int          n_cyc = 0, run_len = 0, n_ovr = 0, n_tmo = 0;
   logic [31:0] cap_adr = '0, cap_dat = '0, cap_wadr = '0;
   logic [3:0]  cap_sel = '0;
   logic        cap_we = 1'b0;
   always @(posedge clk) begin
      cyc_prev <= wb_cyc_o;
      if (wb_cyc_o && !cyc_prev) begin
         n_cyc    <= n_cyc + 1;
         run_len  <= 1;
         cap_adr  <= wb_adr_o;
         cap_dat  <= wb_dat_o;
         cap_sel  <= wb_sel_o;
         cap_we   <= wb_we_o;
         cap_wadr <= w_wb_adr_o;
      end else if (wb_cyc_o) begin
         run_len <= run_len + 1;
      end
      if (overrun_o) n_ovr <= n_ovr + 1;
      if (timeout_o) n_tmo <= n_tmo + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic host_write(input logic [12:0] a, input logic [7:0] d);
      @(negedge clk); host_addr = a; host_di = d; host_ncs = 1'b0;
      @(negedge clk); host_nwe = 1'b0;
      repeat (6) @(negedge clk);
      host_nwe = 1'b1;
      repeat (4) @(negedge clk);
      chk("wr_wait_busy", 32'(host_wait), 32'd1);
      repeat (8) @(negedge clk);
      host_ncs = 1'b1;
      @(negedge clk);
   endtask

   task automatic host_read_start(input logic [12:0] a);
      @(negedge clk); host_addr = a; host_ncs = 1'b0;
      @(negedge clk); host_noe = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   task automatic host_read_end();
      host_noe = 1'b1;
      host_ncs = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   typedef struct {
      logic        wr;
      logic [12:0] addr;
      logic [7:0]  data;
      logic [31:0] rdata;
      logic [31:0] exp_adr;
      logic [3:0]  exp_sel;
      logic [31:0] exp_dat;
      logic [7:0]  exp_do;
      logic [31:0] exp_wadr;
   } vec_t;

   localparam int NV = 6;
   vec_t vec [NV];
   int   c0, o0, t0;
   logic wait_seen;

   initial begin
      vec[0] = '{1'b1, 13'h0005, 8'hA5, 32'h0,        32'h0000_0004, 4'b0100, 32'hA5A5_A5A5, 8'h00, 32'hFFFF_FFF4};
      vec[1] = '{1'b0, 13'h0013, 8'h00, 32'h1122_3344, 32'h0000_0010, 4'b0001, 32'h0,         8'h44, 32'h0000_0000};
      vec[2] = '{1'b1, 13'h0014, 8'h3C, 32'h0,        32'h0000_0014, 4'b1000, 32'h3C3C_3C3C, 8'h00, 32'h0000_0004};
      vec[3] = '{1'b0, 13'h1FFE, 8'h00, 32'hDEAD_BEEF, 32'h0000_1FFC, 4'b0010, 32'h0,         8'hBE, 32'h0000_1FEC};
      vec[4] = '{1'b0, 13'h0101, 8'h00, 32'hCAFE_F00D, 32'h0000_0100, 4'b0100, 32'h0,         8'hFE, 32'h0000_00F0};
      vec[5] = '{1'b1, 13'h0AAB, 8'h5A, 32'h0,        32'h0000_0AA8, 4'b0001, 32'h5A5A_5A5A, 8'h00, 32'h0000_0A98};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_cyc",  32'(wb_cyc_o), 32'd0);
      chk("rst_stb",  32'(wb_stb_o), 32'd0);
      chk("rst_we",   32'(wb_we_o), 32'd0);
      chk("rst_sel",  32'(wb_sel_o), 32'd0);
      chk("rst_adr",  wb_adr_o, 32'd0);
      chk("rst_do",   32'(host_do), 32'd0);
      chk("rst_doe",  32'(host_doe), 32'd0);
      chk("rst_wait", 32'(host_wait), 32'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Table of single accesses
      for (int i = 0; i < NV; i++) begin
         c0 = n_cyc;
         ack_en = 1'b1;
         ack_dly = 1;
         wb_dat_i = vec[i].rdata;
         if (vec[i].wr) begin
            host_write(vec[i].addr, vec[i].data);
            chk($sformatf("v%0d_dat", i), cap_dat, vec[i].exp_dat);
         end else begin
            host_read_start(vec[i].addr);
            chk($sformatf("v%0d_doe_hold", i), 32'(host_doe), 32'd1);
            chk($sformatf("v%0d_do", i), 32'(host_do), 32'(vec[i].exp_do));
            host_read_end();
            chk($sformatf("v%0d_doe_rel", i), 32'(host_doe), 32'd0);
            chk($sformatf("v%0d_do_keep", i), 32'(host_do), 32'(vec[i].exp_do));
         end
         chk($sformatf("v%0d_ncyc", i), 32'(n_cyc - c0), 32'd1);
         chk($sformatf("v%0d_adr", i), cap_adr, vec[i].exp_adr);
         chk($sformatf("v%0d_sel", i), 32'(cap_sel), 32'(vec[i].exp_sel));
         chk($sformatf("v%0d_we", i), 32'(cap_we), 32'(vec[i].wr));
         chk($sformatf("v%0d_wrap_adr", i), cap_wadr, vec[i].exp_wadr);
         chk($sformatf("v%0d_cyc_idle", i), 32'(wb_cyc_o), 32'd0);
      end

      // Illegal strobe: nwe and noe low together
      c0 = n_cyc;
      wait_seen = 1'b0;
      @(negedge clk); host_addr = 13'h0033; host_ncs = 1'b0;
      @(negedge clk); host_nwe = 1'b0; host_noe = 1'b0;
      repeat (4) begin @(negedge clk); wait_seen = wait_seen | host_wait; end
      host_nwe = 1'b1; host_noe = 1'b1;
      repeat (8) begin @(negedge clk); wait_seen = wait_seen | host_wait; end
      host_ncs = 1'b1;
      chk("illegal_wait", 32'(wait_seen), 32'd0);
      chk("illegal_ncyc", 32'(n_cyc - c0), 32'd0);

      // Read timeout with silent slave
      ack_en = 1'b0;
      c0 = n_cyc; t0 = n_tmo;
      wb_dat_i = 32'h1234_5678;
      host_read_start(13'h0008);
      chk("tmo_len",   32'(run_len), 32'd10);
      chk("tmo_pulse", 32'(n_tmo - t0), 32'd1);
      chk("tmo_do",    32'(host_do), 32'h0000_00FF);
      chk("tmo_doe",   32'(host_doe), 32'd1);
      chk("tmo_ncyc",  32'(n_cyc - c0), 32'd1);
      host_read_end();
      chk("tmo_doe_rel", 32'(host_doe), 32'd0);

      // Overrun: second nwe rise while the write is still waiting for ack
      ack_en = 1'b1;
      ack_dly = 6;
      c0 = n_cyc; o0 = n_ovr; t0 = n_tmo;
      @(negedge clk); host_addr = 13'h0040; host_di = 8'h77; host_ncs = 1'b0;
      @(negedge clk); host_nwe = 1'b0;
      repeat (2) @(negedge clk); host_nwe = 1'b1;
      repeat (2) @(negedge clk); host_nwe = 1'b0;
      repeat (2) @(negedge clk); host_nwe = 1'b1;
      repeat (14) @(negedge clk); host_ncs = 1'b1;
      repeat (2) @(negedge clk);
      chk("ovr_pulse", 32'(n_ovr - o0), 32'd1);
      chk("ovr_ncyc",  32'(n_cyc - c0), 32'd1);
      chk("ovr_dat",   cap_dat, 32'h7777_7777);
      chk("ovr_no_tmo", 32'(n_tmo - t0), 32'd0);

      // Asynchronous reset while a write cycle is open
      ack_en = 1'b0;
      @(negedge clk); host_addr = 13'h0005; host_di = 8'h11; host_ncs = 1'b0;
      @(negedge clk); host_nwe = 1'b0;
      repeat (2) @(negedge clk); host_nwe = 1'b1;
      for (int k = 0; k < 20 && !wb_cyc_o; k++) @(negedge clk);
      chk("mrst_cyc_open", 32'(wb_cyc_o), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("mrst_cyc", 32'(wb_cyc_o), 32'd0);
      chk("mrst_stb", 32'(wb_stb_o), 32'd0);
      chk("mrst_we",  32'(wb_we_o), 32'd0);
      chk("mrst_doe", 32'(host_doe), 32'd0);
      chk("mrst_wcyc", 32'(w_wb_cyc_o), 32'd0);
      host_ncs = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("post_rst_cyc",  32'(wb_cyc_o), 32'd0);
      chk("post_rst_wait", 32'(host_wait), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
